// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the motor drive block.
//   - hall_t / phase_t : hall code {h1,h2,h3} and six-bit gate pattern types
//   - FWD_PAT / REV_PAT: six-step commutation tables indexed by hall code
//   - ALL_OFF          : every gate off
//   - is_illegal()     : flags the two hall codes a healthy sensor never shows
//   - commutate()      : pattern for a hall code in the requested direction
package motor_pkg;

  typedef logic [2:0] hall_t;
  typedef logic [5:0] phase_t;

  localparam phase_t ALL_OFF = 6'b000000;

  // Codes 000 and 111 map to ALL_OFF so an illegal code can never drive a gate.
  localparam phase_t FWD_PAT [0:7] = '{
    ALL_OFF, 6'b000110, 6'b011000, 6'b010010,
    6'b100001, 6'b100100, 6'b001001, ALL_OFF
  };

  localparam phase_t REV_PAT [0:7] = '{
    ALL_OFF, 6'b001001, 6'b100100, 6'b100001,
    6'b010010, 6'b011000, 6'b000110, ALL_OFF
  };

  function automatic logic is_illegal(input hall_t code);
    return (code == 3'b000) || (code == 3'b111);
  endfunction

  function automatic phase_t commutate(input logic rev, input hall_t code);
    return rev ? REV_PAT[code] : FWD_PAT[code];
  endfunction

endpackage

// File: rtl/motor_pid.sv
// motor_pid: PID loop with a control-rate divider, clamped integrator with
// anti-windup, and a two-stage multiply / sum-shift-saturate pipeline.
//   clk, rst_n           : clock, asynchronous active-low reset
//   hold                 : forces integrator, err_prev, pipeline and pwm to 0
//   setpoint, state      : signed reference and feedback
//   kp, ki, kd           : signed gains
//   pwm                  : saturated signed loop output (registered)
module motor_pid #(
  parameter int MAX_LIMIT = 500,
  parameter int MIN_LIMIT = -500,
  parameter int I_LIMIT   = 10000,
  parameter int SHIFT     = 0,
  parameter int CTRL_DIV  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic signed [31:0] setpoint,
  input  logic signed [31:0] state,
  input  logic signed [31:0] kp,
  input  logic signed [31:0] ki,
  input  logic signed [31:0] kd,
  output logic signed [31:0] pwm
);

  logic [31:0]        div_q, div_d;
  logic signed [31:0] integ_q, integ_d;
  logic signed [31:0] err_prev_q, err_prev_d;
  logic signed [31:0] pwm_q, pwm_d;
  logic signed [63:0] p_q, p_d, i_q, i_d, d_q, d_d;
  logic               valid_q, valid_d;

  logic               tick;
  logic               windup;
  logic signed [31:0] err;
  logic signed [32:0] integ_sum;
  logic signed [63:0] sum;
  logic signed [63:0] shifted;

  assign tick = (div_q == 32'(CTRL_DIV - 1));
  assign err  = setpoint - state;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    div_d      = tick ? '0 : div_q + 32'd1;
    integ_d    = integ_q;
    err_prev_d = err_prev_q;
    p_d        = p_q;
    i_d        = i_q;
    d_d        = d_q;
    valid_d    = tick;
    pwm_d      = pwm_q;

    integ_sum = 33'(integ_q) + 33'(err);
    // Stop integrating while the output is pinned and the error pushes further out.
    windup = ((pwm_q == 32'(MAX_LIMIT)) && (err > 0)) ||
             ((pwm_q == 32'(MIN_LIMIT)) && (err < 0));

    if (tick) begin
      if (!windup) begin
        if (integ_sum > 33'(I_LIMIT))       integ_d = 32'(I_LIMIT);
        else if (integ_sum < -33'(I_LIMIT)) integ_d = -32'(I_LIMIT);
        else                                integ_d = integ_sum[31:0];
      end
      p_d        = 64'(kp) * 64'(err);
      i_d        = 64'(ki) * 64'(integ_d);
      d_d        = 64'(kd) * (64'(err) - 64'(err_prev_q));
      err_prev_d = err;
    end

    sum     = p_q + i_q + d_q;
    shifted = sum >>> SHIFT;
    if (valid_q) begin
      if (shifted > 64'(MAX_LIMIT))      pwm_d = 32'(MAX_LIMIT);
      else if (shifted < 64'(MIN_LIMIT)) pwm_d = 32'(MIN_LIMIT);
      else                               pwm_d = shifted[31:0];
    end

    if (hold) begin
      div_d      = '0;
      integ_d    = '0;
      err_prev_d = '0;
      p_d        = '0;
      i_d        = '0;
      d_d        = '0;
      valid_d    = 1'b0;
      pwm_d      = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      integ_q    <= '0;
      err_prev_q <= '0;
      p_q        <= '0;
      i_q        <= '0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      pwm_q      <= '0;
    end else begin
      div_q      <= div_d;
      integ_q    <= integ_d;
      err_prev_q <= err_prev_d;
      p_q        <= p_d;
      i_q        <= i_d;
      d_q        <= d_d;
      valid_q    <= valid_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/motor_control_pid.sv
// motor_control_pid: per-motor drive. PID loop -> PWM duty -> six-step hall
// commutation with dead-time, plus latched illegal-hall and stall faults.
//   CLK, reset_n            : clock, asynchronous active-low reset
//   enable                  : low forces idle (gates off, loop cleared)
//   hall1..hall3            : raw asynchronous hall inputs
//   setpoint, state         : signed loop reference / feedback
//   Kp, Ki, Kd              : signed gains
//   clear_fault             : one-cycle pulse clearing both faults
//   PHASES                  : registered gate outputs
//   pwm                     : saturated loop output
//   fault_hall, fault_stall : latched faults
module motor_control_pid
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD   = 2048,
  parameter int MAX_LIMIT    = 500,
  parameter int MIN_LIMIT    = -500,
  parameter int I_LIMIT      = 10000,
  parameter int SHIFT        = 0,
  parameter int CTRL_DIV     = 1,
  parameter int DEADTIME     = 4,
  parameter int STALL_CYCLES = 5000000,
  parameter int STALL_DUTY   = 100
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               hall1,
  input  logic               hall2,
  input  logic               hall3,
  input  logic signed [31:0] setpoint,
  input  logic signed [31:0] state,
  input  logic signed [31:0] Kp,
  input  logic signed [31:0] Ki,
  input  logic signed [31:0] Kd,
  input  logic               clear_fault,
  output logic [5:0]         PHASES,
  output logic signed [31:0] pwm,
  output logic               fault_hall,
  output logic               fault_stall
);

  hall_t       hall_s1_q, hall_s2_q, hall_s3_q;
  logic [1:0]  sync_fill_q;
  logic [31:0] cnt_q, cnt_d, duty_q, duty_d, stall_q, stall_d, dt_q, dt_d;
  logic        dir_q, dir_d;
  phase_t      tgt_q, tgt_d, phases_q, phases_d;
  logic        fault_hall_q, fault_hall_d, fault_stall_q, fault_stall_d;

  logic signed [31:0] pwm_s;
  logic [31:0] pwm_abs, duty_eff;
  logic        dir_eff, drive_on, hall_bad, stall_hit, force_off;
  phase_t      target;

  motor_pid #(
    .MAX_LIMIT (MAX_LIMIT),
    .MIN_LIMIT (MIN_LIMIT),
    .I_LIMIT   (I_LIMIT),
    .SHIFT     (SHIFT),
    .CTRL_DIV  (CTRL_DIV)
  ) u_pid (
    .clk      (CLK),
    .rst_n    (reset_n),
    .hold     (force_off),
    .setpoint (setpoint),
    .state    (state),
    .kp       (Kp),
    .ki       (Ki),
    .kd       (Kd),
    .pwm      (pwm_s)
  );

  always_comb begin
    pwm_abs = pwm_s[31] ? 32'(-pwm_s) : 32'(pwm_s);

    // Duty and direction take effect from count 0 of each period.
    cnt_d    = (cnt_q == 32'(PWM_PERIOD - 1)) ? '0 : cnt_q + 32'd1;
    duty_eff = (cnt_q == '0) ? pwm_abs : duty_q;
    dir_eff  = (cnt_q == '0) ? pwm_s[31] : dir_q;
    duty_d   = duty_eff;
    dir_d    = dir_eff;
    drive_on = (cnt_q < duty_eff);

    // The synchroniser resets to 000; ignore that until real samples arrive.
    hall_bad  = sync_fill_q[1] && is_illegal(hall_s2_q);
    stall_hit = (stall_q >= 32'(STALL_CYCLES));

    fault_hall_d  = clear_fault ? 1'b0 : (fault_hall_q | hall_bad);
    fault_stall_d = clear_fault ? 1'b0 : (fault_stall_q | stall_hit);
    // Next-state fault values so the gates drop on the edge the flag rises.
    force_off     = fault_hall_d | fault_stall_d | ~enable;

    if (hall_s2_q != hall_s3_q)           stall_d = '0;
    else if (pwm_abs >= 32'(STALL_DUTY))  stall_d = stall_hit ? stall_q : stall_q + 32'd1;
    else                                  stall_d = '0;

    target = ALL_OFF;
    if (drive_on && !force_off) target = commutate(dir_eff, hall_s2_q);

    // Dead-time only between two different live patterns; tgt_q holds the
    // pending pattern while the count runs.
    tgt_d    = target;
    dt_d     = dt_q;
    phases_d = phases_q;
    if (target != tgt_q) begin
      if ((tgt_q != ALL_OFF) && (target != ALL_OFF) && (DEADTIME > 0)) begin
        phases_d = ALL_OFF;
        dt_d     = 32'(DEADTIME);
      end else begin
        phases_d = target;
        dt_d     = '0;
      end
    end else if (dt_q != '0) begin
      dt_d = dt_q - 32'd1;
      if (dt_q == 32'd1) phases_d = tgt_q;
    end else begin
      phases_d = tgt_q;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1_q     <= '0;
      hall_s2_q     <= '0;
      hall_s3_q     <= '0;
      sync_fill_q   <= '0;
      cnt_q         <= '0;
      duty_q        <= '0;
      dir_q         <= 1'b0;
      stall_q       <= '0;
      dt_q          <= '0;
      tgt_q         <= ALL_OFF;
      phases_q      <= ALL_OFF;
      fault_hall_q  <= 1'b0;
      fault_stall_q <= 1'b0;
    end else begin
      hall_s1_q     <= {hall1, hall2, hall3};
      hall_s2_q     <= hall_s1_q;
      hall_s3_q     <= hall_s2_q;
      sync_fill_q   <= {sync_fill_q[0], 1'b1};
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      dir_q         <= dir_d;
      stall_q       <= stall_d;
      dt_q          <= dt_d;
      tgt_q         <= tgt_d;
      phases_q      <= phases_d;
      fault_hall_q  <= fault_hall_d;
      fault_stall_q <= fault_stall_d;
    end
  end

  assign PHASES      = phases_q;
  assign pwm         = pwm_s;
  assign fault_hall  = fault_hall_q;
  assign fault_stall = fault_stall_q;

endmodule

// File: tb/tb_motor_control_pid.sv
// Directed bench for motor_control_pid. u_dut1 uses the default parameters;
// u_dut2 shares the inputs but has a 256-cycle PWM period (so a 500 duty is
// 100% on) and a 1000-cycle stall timeout.
module tb_motor_control_pid;

  logic               CLK = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               hall1, hall2, hall3;
  logic signed [31:0] setpoint, state, Kp, Ki, Kd;
  logic               clear_fault;

  logic [5:0]         phases1, phases2;
  logic signed [31:0] pwm1, pwm2;
  logic               fh1, fs1, fh2, fs2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  motor_control_pid u_dut1 (
    .CLK (CLK), .reset_n (reset_n), .enable (enable),
    .hall1 (hall1), .hall2 (hall2), .hall3 (hall3),
    .setpoint (setpoint), .state (state), .Kp (Kp), .Ki (Ki), .Kd (Kd),
    .clear_fault (clear_fault), .PHASES (phases1), .pwm (pwm1),
    .fault_hall (fh1), .fault_stall (fs1)
  );

  motor_control_pid #(.PWM_PERIOD (256), .STALL_CYCLES (1000)) u_dut2 (
    .CLK (CLK), .reset_n (reset_n), .enable (enable),
    .hall1 (hall1), .hall2 (hall2), .hall3 (hall3),
    .setpoint (setpoint), .state (state), .Kp (Kp), .Ki (Ki), .Kd (Kd),
    .clear_fault (clear_fault), .PHASES (phases2), .pwm (pwm2),
    .fault_hall (fh2), .fault_stall (fs2)
  );

  task automatic set_hall(input logic [2:0] h);
    hall1 = h[2];
    hall2 = h[1];
    hall3 = h[0];
  endtask

  // Disable for a few cycles (clears the loop), then enable with a clear pulse.
  // Returns on the first falling edge after the enabling edge.
  task automatic restart();
    @(negedge CLK);
    enable = 1'b0;
    repeat (5) @(negedge CLK);
    enable      = 1'b1;
    clear_fault = 1'b1;
    @(negedge CLK);
    clear_fault = 1'b0;
  endtask

  // Tally one 2048-cycle window of u_dut1 gate outputs.
  task automatic count_window(input logic [5:0] pat, output int n_pat,
                              output int n_off, output int n_other);
    n_pat = 0; n_off = 0; n_other = 0;
    repeat (2048) begin
      @(negedge CLK);
      if (phases1 == pat)        n_pat++;
      else if (phases1 == 6'b0)  n_off++;
      else                       n_other++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; clear_fault = 1'b0;
    setpoint = 0; state = 0; Kp = 0; Ki = 0; Kd = 0;
    set_hall(3'b101);
    repeat (4) @(negedge CLK);
    n_cmp++; if (phases1 !== 6'b0) begin n_bad++; $display("FAIL reset_phases1: got %b want 000000", phases1); end
    n_cmp++; if (pwm1 !== 32'sd0) begin n_bad++; $display("FAIL reset_pwm1: got %0d want 0", pwm1); end
    n_cmp++; if ({fh1, fs1} !== 2'b00) begin n_bad++; $display("FAIL reset_faults1: got %b want 00", {fh1, fs1}); end
    n_cmp++; if ({phases2, fh2, fs2} !== 8'b0) begin n_bad++; $display("FAIL reset_dut2: got %b want 0", {phases2, fh2, fs2}); end
    reset_n = 1'b1;
    repeat (4) @(negedge CLK);
    n_cmp++; if (fh1 !== 1'b0) begin n_bad++; $display("FAIL reset_no_hall_fault: got %b want 0", fh1); end
  endtask

  task automatic test_forward();
    int n_pat, n_off, n_other;
    Kp = 1; Ki = 0; Kd = 0; setpoint = 300; state = 0;
    set_hall(3'b101);
    restart();
    repeat (3000) @(negedge CLK);
    n_cmp++; if (pwm1 !== 32'sd300) begin n_bad++; $display("FAIL fwd_pwm: got %0d want 300", pwm1); end
    count_window(6'b100100, n_pat, n_off, n_other);
    n_cmp++; if (n_pat !== 300) begin n_bad++; $display("FAIL fwd_on_cycles: got %0d want 300", n_pat); end
    n_cmp++; if (n_off !== 1748) begin n_bad++; $display("FAIL fwd_off_cycles: got %0d want 1748", n_off); end
    n_cmp++; if (n_other !== 0) begin n_bad++; $display("FAIL fwd_other_cycles: got %0d want 0", n_other); end
  endtask

  task automatic test_reverse_sat();
    int n_pat, n_off, n_other;
    setpoint = -10000;
    set_hall(3'b010);
    repeat (3000) @(negedge CLK);
    n_cmp++; if (pwm1 !== -32'sd500) begin n_bad++; $display("FAIL rev_pwm: got %0d want -500", pwm1); end
    count_window(6'b100100, n_pat, n_off, n_other);
    n_cmp++; if (n_pat !== 500) begin n_bad++; $display("FAIL rev_on_cycles: got %0d want 500", n_pat); end
    n_cmp++; if (n_other !== 0) begin n_bad++; $display("FAIL rev_other_cycles: got %0d want 0", n_other); end
  endtask

  // Kp=Kd=1, err=100: first tick sum = 100 + 100, second tick sum = 100 + 0.
  task automatic test_pd_latency();
    Kp = 1; Ki = 0; Kd = 1; setpoint = 100; state = 0;
    set_hall(3'b101);
    restart();
    @(negedge CLK);
    n_cmp++; if (pwm1 !== 32'sd200) begin n_bad++; $display("FAIL pd_first: got %0d want 200", pwm1); end
    @(negedge CLK);
    n_cmp++; if (pwm1 !== 32'sd100) begin n_bad++; $display("FAIL pd_second: got %0d want 100", pwm1); end
  endtask

  task automatic test_deadtime();
    logic [5:0] exp_ph [8];
    exp_ph[0] = 6'b100100; exp_ph[1] = 6'b100100;
    exp_ph[2] = 6'b000000; exp_ph[3] = 6'b000000;
    exp_ph[4] = 6'b000000; exp_ph[5] = 6'b000000;
    exp_ph[6] = 6'b100001; exp_ph[7] = 6'b100001;
    Kp = 1; Ki = 0; Kd = 0; setpoint = 300; state = 0;
    set_hall(3'b101);
    restart();
    repeat (300) @(negedge CLK);
    n_cmp++; if (phases2 !== 6'b100100) begin n_bad++; $display("FAIL dt_full_on: got %b want 100100", phases2); end
    set_hall(3'b100);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (phases2 !== exp_ph[i]) begin
        n_bad++; $display("FAIL dt_step%0d: got %b want %b", i, phases2, exp_ph[i]);
      end
    end
  endtask

  task automatic test_illegal_hall();
    int n_pat, n_off, n_other;
    Kp = 1; Ki = 0; Kd = 0; setpoint = 300; state = 0;
    set_hall(3'b101);
    restart();
    repeat (10) @(negedge CLK);
    set_hall(3'b111);
    repeat (2) @(negedge CLK);
    n_cmp++; if (fh1 !== 1'b0) begin n_bad++; $display("FAIL hall_early: got %b want 0", fh1); end
    @(negedge CLK);
    n_cmp++; if (fh1 !== 1'b1) begin n_bad++; $display("FAIL hall_latch: got %b want 1", fh1); end
    n_cmp++; if (phases1 !== 6'b0) begin n_bad++; $display("FAIL hall_phases: got %b want 000000", phases1); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (pwm1 !== 32'sd0) begin n_bad++; $display("FAIL hall_pwm_forced: got %0d want 0", pwm1); end
    clear_fault = 1'b1;
    @(negedge CLK);
    clear_fault = 1'b0;
    n_cmp++; if (fh1 !== 1'b0) begin n_bad++; $display("FAIL hall_clear: got %b want 0", fh1); end
    @(negedge CLK);
    n_cmp++; if (fh1 !== 1'b1) begin n_bad++; $display("FAIL hall_relatch: got %b want 1", fh1); end
    set_hall(3'b101);
    repeat (4) @(negedge CLK);
    n_cmp++; if (fh1 !== 1'b1) begin n_bad++; $display("FAIL hall_held: got %b want 1", fh1); end
    clear_fault = 1'b1;
    @(negedge CLK);
    clear_fault = 1'b0;
    n_cmp++; if (fh1 !== 1'b0) begin n_bad++; $display("FAIL hall_cleared: got %b want 0", fh1); end
    repeat (2100) @(negedge CLK);
    count_window(6'b100100, n_pat, n_off, n_other);
    n_cmp++; if (n_pat !== 300) begin n_bad++; $display("FAIL hall_resume: got %0d want 300", n_pat); end
  endtask

  task automatic test_stall();
    int  k;
    logic seen;
    Kp = 1; Ki = 0; Kd = 0; setpoint = 300; state = 0;
    set_hall(3'b101);
    repeat (5) @(negedge CLK);
    restart();
    k = 1;
    while (!fs2 && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    n_cmp++;
    if (!(fs2 === 1'b1 && k >= 1001 && k <= 1005)) begin
      n_bad++; $display("FAIL stall_time: got fault=%b at cycle %0d want 1 near 1003", fs2, k);
    end
    n_cmp++; if (phases2 !== 6'b0) begin n_bad++; $display("FAIL stall_phases: got %b want 000000", phases2); end
    restart();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (500) begin
        @(negedge CLK);
        if (fs2) seen = 1'b1;
      end
      set_hall((i % 2 == 0) ? 3'b100 : 3'b101);
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL stall_toggling: got fault=%b want 0", seen); end
  endtask

  task automatic test_integrator();
    Kp = 0; Ki = 1; Kd = 0; setpoint = 100; state = 0;
    set_hall(3'b101);
    restart();
    repeat (50) @(negedge CLK);
    n_cmp++; if (pwm1 !== 32'sd500) begin n_bad++; $display("FAIL integ_small_pwm: got %0d want 500", pwm1); end
    n_cmp++; if (u_dut1.u_pid.integ_q !== 32'sd600) begin n_bad++; $display("FAIL integ_windup: got %0d want 600", u_dut1.u_pid.integ_q); end
    setpoint = 5000;
    restart();
    repeat (50) @(negedge CLK);
    n_cmp++; if (pwm1 !== 32'sd500) begin n_bad++; $display("FAIL integ_big_pwm: got %0d want 500", pwm1); end
    n_cmp++; if (u_dut1.u_pid.integ_q !== 32'sd10000) begin n_bad++; $display("FAIL integ_clamp: got %0d want 10000", u_dut1.u_pid.integ_q); end
  endtask

  task automatic test_reset_mid();
    Kp = 1; Ki = 0; Kd = 0; setpoint = 300; state = 0;
    restart();
    repeat (100) @(negedge CLK);
    set_hall(3'b111);
    repeat (5) @(negedge CLK);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (phases1 !== 6'b0 || phases2 !== 6'b0) begin n_bad++; $display("FAIL rst_mid_phases: got %b/%b want 0", phases1, phases2); end
    n_cmp++; if (pwm1 !== 32'sd0) begin n_bad++; $display("FAIL rst_mid_pwm: got %0d want 0", pwm1); end
    n_cmp++; if ({fh1, fs1, fh2, fs2} !== 4'b0) begin n_bad++; $display("FAIL rst_mid_faults: got %b want 0000", {fh1, fs1, fh2, fs2}); end
    n_cmp++; if (u_dut1.u_pid.integ_q !== 32'sd0) begin n_bad++; $display("FAIL rst_mid_integ: got %0d want 0", u_dut1.u_pid.integ_q); end
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_sat();
    test_pd_latency();
    test_deadtime();
    test_illegal_hall();
    test_stall();
    test_integrator();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
